img_frame_packer: RTL and testbench
===================================

# img_frame_packer

Parametrised successor to the camera-side image-processing control FSM. It takes the downsampled pixel stream (pixel valid + data, plus the frame-valid line) from the capture pipeline and packs a fixed-size image into wide DMEM words. It writes those words into one of `NUM_BUF` ping-pong buffers. Single-shot and continuous capture modes are both supported, and a CPU enable/done handshake controls capture. It sits between the crop/downsample stage and the 256-bit DMEM write port.

## Interface
Parameters:
- `PIX_W`, 16: bits per pixel lane.
- `LANES`, 16: pixels per DMEM word; word width is `WORD_W = PIX_W*LANES`.
- `N_PIX`, 784: pixels per image (28x28).
- `NUM_BUF`, 2: number of image buffers in DMEM.
- `ADDR_W`, 7: DMEM word address width.
- `BASE_ADDR`, 0: word address of buffer 0.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- `pxlclk`, in, 1: pixel clock. All logic is on the rising edge.
- `rst_n`, in, 1: synchronous active-low reset.
- `iCCD_enable`, in, 1: CPU capture enable, level-sensitive.
- `iMode`, in, 1: 0 = single-shot, 1 = continuous. Sampled on leaving IDLE.
- `iFVAL`, in, 1: frame valid.
- `iDVAL`, in, 1: pixel valid.
- `iDATA`, in, `PIX_W`: pixel data.
- `oCCD_done`, out, 1: image complete.
- `oBuf`, out, `$clog2(NUM_BUF)` (minimum 1): index of the last completed buffer.
- `oDrop`, out, 8: count of short frames, saturating.
- `oDmem_wren`, out, 1: DMEM write strobe.
- `oDmem_addr`, out, `ADDR_W`: DMEM word address.
- `oDmem_data`, out, `WORD_W`: DMEM write data.

## Operation
- Derived constant: `WORDS = ceil(N_PIX/LANES)`, which is 49 at default parameters.
- Elaboration check: `BASE_ADDR + NUM_BUF*WORDS <= 2**ADDR_W`.
- States:
  - **IDLE**: when `iCCD_enable` is 1, latch `iMode`, clear the pixel and word counters, and go to ARMED.
  - **ARMED**: wait for a rising edge of `iFVAL`, registered against the previous sample, then go to CAPTURE. A frame already in progress when ARMED is entered is skipped.
  - **CAPTURE**: each cycle with `iDVAL`=1, put `iDATA` into lane `pix % LANES`. The first pixel of a word goes to bits `[PIX_W-1:0]`.
    - Write a word when its last lane fills, or when pixel `N_PIX` is accepted.
    - For a partial final word, unfilled lanes are 0.
    - Write address is `BASE_ADDR + buf*WORDS + word_idx`.
    - After pixel `N_PIX`, go to DONE. Further `iDVAL` in that frame is ignored.
  - **Short frame**: if `iFVAL` falls in CAPTURE before `N_PIX` pixels:
    - increment `oDrop`, saturating at 255;
    - reset counters, keeping the same buffer;
    - return to ARMED.
    - Words already written are simply overwritten by the retry.
  - **DONE**:
    - Single-shot: set `oCCD_done`=1, `oBuf`=buf, then hold until `iCCD_enable`=0, which returns to IDLE with done cleared.
    - Continuous: `oCCD_done` pulses for 1 cycle, `oBuf`=buf, buf advances modulo `NUM_BUF`, and the FSM goes to ARMED. An `iCCD_enable` of 0 in DONE returns to IDLE.
- **Enable dropped** in ARMED or CAPTURE: abort to IDLE on the next edge, with no further writes. The partial word is discarded.
- **`iFVAL` rise and `iDVAL` in the same cycle in ARMED**: that pixel is not captured. Capture begins the next cycle.

## Timing
- On reset, all outputs are 0, the FSM is in IDLE, buf=0, and `oDrop`=0. Mid-operation reset takes effect at the next edge.
- Write latency: `oDmem_wren`/`oDmem_addr`/`oDmem_data` are registered. They assert for exactly 1 cycle, on the edge after the pixel that completes the word.
- `oCCD_done` asserts on the cycle after the final write's `wren`.
- Maximum one write per `LANES` accepted pixels, plus at most one flush write per image.
- No backpressure: the DMEM port accepts a write every cycle.

## Structure
- Package `ipsm_pkg`:
  - state enum (IDLE, ARMED, CAPTURE, DONE);
  - mode constants;
  - a `words_for(n, lanes)` ceiling function.
- Sub-module `lane_packer`: shift/lane register, lane counter, word-complete/flush output, zero fill. The top holds the FSM, address generation, and buffer and drop counters.

## Test plan
- **Single-shot, default parameters**: enable=1, one frame of 784 pixels with values 0..783.
  - 49 writes at addresses 0..48.
  - Word 0 lane 0 = 0 and lane 15 = 15.
  - Word 48 lanes 0..15 = 768..783.
  - Done goes to 1 and holds, then clears one cycle after enable=0.
- **`N_PIX`=20, `LANES`=16**: 2 writes.
  - Second word lanes 0..3 = pixels 16..19, lanes 4..15 = 0.
  - Done the cycle after the second `wren`.
- **Continuous, `NUM_BUF`=2**: 3 frames.
  - Base addresses 0, 49, 0.
  - `oBuf` sequence 0, 1, 0.
  - Three 1-cycle done pulses.
- **Short frame**: `iFVAL` falls after 100 pixels.
  - `oDrop`=1, no done.
  - The next full frame rewrites from address 0 and done asserts.
- **Abort**: enable→0 after 40 pixels.
  - Exactly 2 writes occurred and none after.
  - FSM in IDLE; re-enable captures cleanly from word 0.
- **Late start**: enable asserted mid-frame.
  - No writes until the next `iFVAL` rise.
  - Pixels with `iDVAL` coincident with the rise are not captured.

Source files
------------

// File: rtl/ipsm_pkg.sv
// Shared state encoding, capture-mode constants and sizing helper for the image frame packer.
package ipsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } ipsm_state_t;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_CONT   = 1'b1;

    function automatic int words_for(input int n, input int lanes);
        return (n + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/img_frame_packer_lane_packer.sv
// Packs accepted pixels into a wide word, lane 0 in the low bits, zero-filling a flushed partial word.
// word_vld/word_dat register one edge after the completing pixel; never stalls its input.
module lane_packer
    import ipsm_pkg::*;
#(
    parameter int PIX_W = 16,
    parameter int LANES = 16
) (
    input  logic                   pxlclk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   pix_vld,
    input  logic                   last,
    input  logic [PIX_W-1:0]       pix_dat,
    output logic                   fire,
    output logic                   word_vld,
    output logic [PIX_W*LANES-1:0] word_dat
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES-1:0][PIX_W-1:0] acc;
    logic [LANES-1:0][PIX_W-1:0] acc_nxt;
    logic [LW-1:0]               lane_cnt;

    always_comb begin
        acc_nxt           = acc;
        acc_nxt[lane_cnt] = pix_dat;
    end

    assign fire = pix_vld && ((lane_cnt == LW'(LANES - 1)) || last);

    // acc is cleared after every word, so lanes beyond a flush point read back as zero
    always_ff @(posedge pxlclk) begin
        if (!rst_n) begin
            acc      <= '0;
            lane_cnt <= '0;
            word_vld <= 1'b0;
            word_dat <= '0;
        end else begin
            word_vld <= fire;
            if (fire) begin
                word_dat <= acc_nxt;
            end
            if (clr || fire) begin
                acc      <= '0;
                lane_cnt <= '0;
            end else if (pix_vld) begin
                acc      <= acc_nxt;
                lane_cnt <= lane_cnt + LW'(1);
            end
        end
    end

endmodule

// File: rtl/img_frame_packer.sv
// Captures one fixed-size image per frame into ping-pong DMEM buffers, single-shot or continuous.
// DMEM write is registered one edge after the completing pixel; no backpressure, DMEM takes a word every cycle.
module img_frame_packer
    import ipsm_pkg::*;
#(
    parameter  int PIX_W     = 16,
    parameter  int LANES     = 16,
    parameter  int N_PIX     = 784,
    parameter  int NUM_BUF   = 2,
    parameter  int ADDR_W    = 7,
    parameter  int BASE_ADDR = 0,
    localparam int WORD_W    = PIX_W * LANES,
    localparam int BUF_W     = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
    input  logic              pxlclk,
    input  logic              rst_n,
    input  logic              iCCD_enable,
    input  logic              iMode,
    input  logic              iFVAL,
    input  logic              iDVAL,
    input  logic [PIX_W-1:0]  iDATA,
    output logic              oCCD_done,
    output logic [BUF_W-1:0]  oBuf,
    output logic [7:0]        oDrop,
    output logic              oDmem_wren,
    output logic [ADDR_W-1:0] oDmem_addr,
    output logic [WORD_W-1:0] oDmem_data
);

    localparam int                WORDS    = words_for(N_PIX, LANES);
    localparam int                PC_W     = $clog2(N_PIX + 1);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] WORDS_A  = ADDR_W'(WORDS);
    localparam logic [BUF_W-1:0]  LAST_BUF = BUF_W'(NUM_BUF - 1);

    generate
        if (BASE_ADDR + NUM_BUF * WORDS > 2 ** ADDR_W) begin : g_addr_check
            $error("img_frame_packer: image buffers do not fit in the DMEM address space");
        end
    endgenerate

    ipsm_state_t       state;
    logic              mode_q;
    logic              fval_q;
    logic [PC_W-1:0]   pix_cnt;
    logic [ADDR_W-1:0] word_idx;
    logic [BUF_W-1:0]  buf_idx;
    logic [ADDR_W-1:0] buf_base;
    logic              cap_active;
    logic              pix_vld;
    logic              last_pix;
    logic              fire;

    // Dropping enable or frame-valid stops acceptance in the same cycle and discards the partial word
    assign cap_active = (state == ST_CAPTURE) && iCCD_enable && iFVAL;
    assign pix_vld    = cap_active && iDVAL;
    assign last_pix   = (pix_cnt == PC_W'(N_PIX - 1));

    lane_packer #(
        .PIX_W (PIX_W),
        .LANES (LANES)
    ) u_lane_packer (
        .pxlclk   (pxlclk),
        .rst_n    (rst_n),
        .clr      (!cap_active),
        .pix_vld  (pix_vld),
        .last     (last_pix),
        .pix_dat  (iDATA),
        .fire     (fire),
        .word_vld (oDmem_wren),
        .word_dat (oDmem_data)
    );

    always_ff @(posedge pxlclk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_SINGLE;
            fval_q     <= 1'b0;
            pix_cnt    <= '0;
            word_idx   <= '0;
            buf_idx    <= '0;
            buf_base   <= BASE_A;
            oCCD_done  <= 1'b0;
            oBuf       <= '0;
            oDrop      <= '0;
            oDmem_addr <= '0;
        end else begin
            fval_q    <= iFVAL;
            oCCD_done <= 1'b0;
            if (fire) begin
                oDmem_addr <= buf_base + word_idx;
                word_idx   <= word_idx + ADDR_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (iCCD_enable) begin
                        mode_q   <= iMode;
                        pix_cnt  <= '0;
                        word_idx <= '0;
                        state    <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (!iCCD_enable) begin
                        state <= ST_IDLE;
                    end else if (iFVAL && !fval_q) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (!iCCD_enable) begin
                        state <= ST_IDLE;
                    end else if (!iFVAL) begin
                        if (oDrop != 8'hFF) begin
                            oDrop <= oDrop + 8'd1;
                        end
                        pix_cnt  <= '0;
                        word_idx <= '0;
                        state    <= ST_ARMED;
                    end else if (iDVAL) begin
                        if (last_pix) begin
                            pix_cnt  <= '0;
                            word_idx <= '0;
                            state    <= ST_DONE;
                        end else begin
                            pix_cnt <= pix_cnt + PC_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (!iCCD_enable) begin
                        state <= ST_IDLE;
                    end else begin
                        oCCD_done <= 1'b1;
                        oBuf      <= buf_idx;
                        if (mode_q == MODE_CONT) begin
                            if (buf_idx == LAST_BUF) begin
                                buf_idx  <= '0;
                                buf_base <= BASE_A;
                            end else begin
                                buf_idx  <= buf_idx + BUF_W'(1);
                                buf_base <= buf_base + WORDS_A;
                            end
                            state <= ST_ARMED;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_img_frame_packer.sv
// Directed bench: default 784-pixel packer plus a 20-pixel instance fed from the same pixel stream.
module tb_img_frame_packer;

    typedef struct {
        logic [6:0]   addr;
        logic [255:0] data;
        int           cyc;
    } wr_t;

    typedef struct {
        int cyc;
        int bufi;
    } dn_t;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         mode;
    logic         fval;
    logic         dval;
    logic [15:0]  data;

    logic         done;
    logic [0:0]   bufo;
    logic [7:0]   drop;
    logic         wren;
    logic [6:0]   addr;
    logic [255:0] wdat;

    logic         d20_done;
    logic [0:0]   d20_buf;
    logic [7:0]   d20_drop;
    logic         d20_wren;
    logic [6:0]   d20_addr;
    logic [255:0] d20_wdat;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    wr_t wq[$];
    wr_t wq20[$];
    dn_t dq[$];
    dn_t dq20[$];

    img_frame_packer dut (
        .pxlclk      (clk),
        .rst_n       (rst_n),
        .iCCD_enable (en),
        .iMode       (mode),
        .iFVAL       (fval),
        .iDVAL       (dval),
        .iDATA       (data),
        .oCCD_done   (done),
        .oBuf        (bufo),
        .oDrop       (drop),
        .oDmem_wren  (wren),
        .oDmem_addr  (addr),
        .oDmem_data  (wdat)
    );

    img_frame_packer #(.N_PIX(20)) dut20 (
        .pxlclk      (clk),
        .rst_n       (rst_n),
        .iCCD_enable (en),
        .iMode       (mode),
        .iFVAL       (fval),
        .iDVAL       (dval),
        .iDATA       (data),
        .oCCD_done   (d20_done),
        .oBuf        (d20_buf),
        .oDrop       (d20_drop),
        .oDmem_wren  (d20_wren),
        .oDmem_addr  (d20_addr),
        .oDmem_data  (d20_wdat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wren)     wq.push_back('{addr, wdat, cyc});
        if (d20_wren) wq20.push_back('{d20_addr, d20_wdat, cyc});
        if (done)     dq.push_back('{cyc, int'(bufo)});
        if (d20_done) dq20.push_back('{cyc, int'(d20_buf)});
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic wr_t wget(input int i);
        wr_t z = '{7'd0, 256'd0, 0};
        if (i < wq.size()) return wq[i];
        return z;
    endfunction

    function automatic wr_t wget20(input int i);
        wr_t z = '{7'd0, 256'd0, 0};
        if (i < wq20.size()) return wq20[i];
        return z;
    endfunction

    function automatic dn_t dget(input int i);
        dn_t z = '{-1, -1};
        if (i < dq.size()) return dq[i];
        return z;
    endfunction

    function automatic logic [255:0] word_of(input int first, input int nfill);
        logic [255:0] w = '0;
        for (int l = 0; l < nfill; l++) w[l*16 +: 16] = 16'(first + l);
        return w;
    endfunction

    task automatic clear_logs();
        wq.delete();
        wq20.delete();
        dq.delete();
        dq20.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pixels(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 dval = 1'b1;
            data = 16'(base + i);
        end
    endtask

    task automatic end_frame(input int gap);
        @(posedge clk);
        #1 dval = 1'b0;
        fval = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic frame(input int n, input bit dval_at_rise, input int gap);
        @(posedge clk);
        #1 fval = 1'b1;
        dval = dval_at_rise;
        data = 16'hBEEF;
        pixels(n, 0);
        end_frame(gap);
    endtask

    initial begin
        int aerr;
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 1'b0;
        fval  = 1'b0;
        dval  = 1'b0;
        data  = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wren", 256'(wren), 256'd0);
        chk("rst_done", 256'(done), 256'd0);
        chk("rst_drop", 256'(drop), 256'd0);
        chk("rst_buf",  256'(bufo), 256'd0);
        chk("rst_addr", 256'(addr), 256'd0);
        chk("rst_data", wdat, 256'd0);
        #1 rst_n = 1'b1;

        // single-shot, one full frame 0..783
        clear_logs();
        en = 1'b1;
        mode = 1'b0;
        repeat (2) @(posedge clk);
        frame(784, 1'b0, 5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ss_nwr", 256'(wq.size()), 256'd49);
        aerr = 0;
        for (int i = 0; i < 49; i++) if (int'(wget(i).addr) != i) aerr++;
        chk("ss_addr_seq", 256'(aerr), 256'd0);
        chk("ss_w0_l0",  256'(wget(0).data[15:0]), 256'd0);
        chk("ss_w0_l15", 256'(wget(0).data[255:240]), 256'd15);
        chk("ss_w48", wget(48).data, word_of(768, 16));
        chk("ss_done_hold", 256'(done), 256'd1);
        chk("ss_done_cyc", 256'(dget(0).cyc), 256'(wget(48).cyc + 1));
        chk("ss_buf", 256'(bufo), 256'd0);
        chk("n20_nwr", 256'(wq20.size()), 256'd2);
        chk("n20_w1", wget20(1).data, word_of(16, 4));
        chk("n20_w1_addr", 256'(wget20(1).addr), 256'd1);
        chk("n20_done_cyc", 256'((dq20.size() > 0) ? dq20[0].cyc : -1), 256'(wget20(1).cyc + 1));
        @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        chk("ss_done_still", 256'(done), 256'd1);
        @(negedge clk);
        chk("ss_done_clr", 256'(done), 256'd0);
        chk("n20_done_clr", 256'(d20_done), 256'd0);

        // continuous, three frames over two buffers
        clear_logs();
        mode = 1'b1;
        #1 en = 1'b1;
        repeat (2) @(posedge clk);
        for (int f = 0; f < 3; f++) frame(784, 1'b0, 4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ct_nwr", 256'(wq.size()), 256'd147);
        chk("ct_base0", 256'(wget(0).addr), 256'd0);
        chk("ct_base1", 256'(wget(49).addr), 256'd49);
        chk("ct_base2", 256'(wget(98).addr), 256'd0);
        chk("ct_ndone", 256'(dq.size()), 256'd3);
        chk("ct_buf0", 256'(dget(0).bufi), 256'd0);
        chk("ct_buf1", 256'(dget(1).bufi), 256'd1);
        chk("ct_buf2", 256'(dget(2).bufi), 256'd0);
        chk("ct_done_cyc", 256'(dget(2).cyc), 256'(wget(146).cyc + 1));
        #1 en = 1'b0;
        repeat (2) @(posedge clk);

        // short frame, then full retry into the same buffer
        #1 do_reset();
        clear_logs();
        mode = 1'b0;
        en = 1'b1;
        repeat (2) @(posedge clk);
        frame(100, 1'b0, 4);
        @(negedge clk);
        chk("sh_drop", 256'(drop), 256'd1);
        chk("sh_nodone", 256'(dq.size()), 256'd0);
        chk("sh_nwr", 256'(wq.size()), 256'd6);
        frame(784, 1'b0, 4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sh_retry_addr", 256'(wget(6).addr), 256'd0);
        chk("sh_retry_nwr", 256'(wq.size()), 256'd55);
        chk("sh_retry_w0", wget(6).data, word_of(0, 16));
        chk("sh_retry_done", 256'(done), 256'd1);
        chk("sh_drop_keep", 256'(drop), 256'd1);

        // abort after 40 pixels, then a clean recapture
        #1 en = 1'b0;
        repeat (2) @(posedge clk);
        clear_logs();
        #1 en = 1'b1;
        repeat (2) @(posedge clk);
        #1 fval = 1'b1;
        dval = 1'b0;
        pixels(40, 0);
        @(posedge clk);
        #1 en = 1'b0;
        dval = 1'b1;
        data = 16'd40;
        pixels(20, 41);
        end_frame(4);
        @(negedge clk);
        chk("ab_nwr", 256'(wq.size()), 256'd2);
        chk("ab_addr1", 256'(wget(1).addr), 256'd1);
        chk("ab_nodone", 256'(done), 256'd0);
        #1 en = 1'b1;
        repeat (2) @(posedge clk);
        frame(784, 1'b0, 4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ab_re_nwr", 256'(wq.size()), 256'd51);
        chk("ab_re_addr", 256'(wget(2).addr), 256'd0);
        chk("ab_re_w0", wget(2).data, word_of(0, 16));
        chk("ab_re_done", 256'(done), 256'd1);

        // late start: enable mid-frame, then a rise carrying a pixel
        #1 en = 1'b0;
        repeat (2) @(posedge clk);
        clear_logs();
        @(posedge clk);
        #1 fval = 1'b1;
        pixels(30, 1000);
        @(posedge clk);
        #1 en = 1'b1;
        dval = 1'b1;
        data = 16'd1030;
        pixels(30, 1031);
        end_frame(4);
        @(negedge clk);
        chk("ls_nowr", 256'(wq.size()), 256'd0);
        frame(784, 1'b1, 4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ls_nwr", 256'(wq.size()), 256'd49);
        chk("ls_w0", wget(0).data, word_of(0, 16));
        chk("ls_w48", wget(48).data, word_of(768, 16));
        chk("ls_done", 256'(done), 256'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
